// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared definitions for the 4x4 keypad scanner: scan phase
//                count, scan-result and state encodings, key code constants
//                for the game/control logic, and the scan classifier.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    // Cycles each column is driven: two settle/sync cycles, one sample cycle.
    localparam int SCAN_PHASES = 3;

    // Outcome of one complete scan of the matrix.
    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_t;

    // Debounce / press-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // Key codes as seen by the game logic: code = row*4 + col.
    localparam logic [3:0] c_KEY_R0_C0 = 4'd0;
    localparam logic [3:0] c_KEY_R0_C1 = 4'd1;
    localparam logic [3:0] c_KEY_R0_C2 = 4'd2;
    localparam logic [3:0] c_KEY_R0_C3 = 4'd3;
    localparam logic [3:0] c_KEY_R1_C0 = 4'd4;
    localparam logic [3:0] c_KEY_R1_C1 = 4'd5;
    localparam logic [3:0] c_KEY_R1_C2 = 4'd6;
    localparam logic [3:0] c_KEY_R1_C3 = 4'd7;
    localparam logic [3:0] c_KEY_R2_C0 = 4'd8;
    localparam logic [3:0] c_KEY_R2_C1 = 4'd9;
    localparam logic [3:0] c_KEY_R2_C2 = 4'd10;
    localparam logic [3:0] c_KEY_R2_C3 = 4'd11;
    localparam logic [3:0] c_KEY_R3_C0 = 4'd12;
    localparam logic [3:0] c_KEY_R3_C1 = 4'd13;
    localparam logic [3:0] c_KEY_R3_C2 = 4'd14;
    localparam logic [3:0] c_KEY_R3_C3 = 4'd15;

    // The hit count is saturated at 2, so 2 already means "two or more".
    function automatic scan_res_t classify_hits(input logic [1:0] hits);
        scan_res_t res;
        case (hits)
            2'd0:    res = RES_NONE;
            2'd1:    res = RES_SINGLE;
            default: res = RES_MULTI;
        endcase
        return res;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/row_sync.sv
`default_nettype none
// ============================================================================
//  Module      : row_sync
//  Description : Two-flop synchronizer for the asynchronous keypad row lines.
//                Resets to all ones (the idle, pulled-up level of the rows).
//  Ports       : clk_in   - scan clock
//                reset    - synchronous active-high reset
//                i_async  - asynchronous input bus, WIDTH bits
//                o_sync   - synchronized output bus, WIDTH bits
//  Revision    : 1.0  initial release
// ============================================================================
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_meta <= '1;
            o_sync <= '1;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule : row_sync
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a ROWS x COLS matrix keypad with active-low one-hot
//                column drive, synchronizes and samples the rows, classifies
//                each full scan, and debounces presses and releases across
//                DEBOUNCE_SCANS consecutive identical scans.
//  Ports       : clk_in    - scan clock (~1 kHz, from the clock divider)
//                reset     - synchronous active-high reset
//                row_in    - keypad rows, active-low, asynchronous
//                col_out   - column drive, active-low one-hot (registered)
//                key_code  - last accepted key, row*COLS + col (registered)
//                key_valid - one-cycle pulse on an accepted press (registered)
//                key_held  - high while the accepted key is down (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COLS           = 4,
    parameter int ROWS           = 4,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int KEY_W          = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_PH_W  = $clog2(SCAN_PHASES);
    localparam int c_CNT_W = 4;

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [ROWS-1:0] w_rows_sync;

    row_sync #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .i_async (row_in),
        .o_sync  (w_rows_sync)
    );

    // ------------------------------------------------------------------
    // Column sequencing and per-scan accumulation
    // ------------------------------------------------------------------
    logic [c_PH_W-1:0]  r_phase;
    logic [c_COL_W-1:0] r_col;
    logic               r_scan_end;
    logic [1:0]         r_hits;     // saturating: 0, 1, 2 = two or more
    logic [KEY_W-1:0]   r_first;

    logic               w_sample;
    logic               w_last_col;
    logic [1:0]         w_col_hits;
    logic [KEY_W-1:0]   w_col_first;
    logic [2:0]         w_hit_sum;

    assign w_sample   = (r_phase == c_PH_W'(SCAN_PHASES - 1));
    assign w_last_col = (r_col == c_COL_W'(COLS - 1));
    assign w_hit_sum  = {1'b0, r_hits} + {1'b0, w_col_hits};

    // Hits in the column currently being sampled. Rows are walked from the
    // top down so the lowest pressed row is the one left in w_col_first.
    always_comb begin
        w_col_hits  = 2'd0;
        w_col_first = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!w_rows_sync[r]) begin
                w_col_first = KEY_W'(r * COLS + int'(r_col));
                if (w_col_hits != 2'd2) begin
                    w_col_hits = w_col_hits + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_phase    <= '0;
            r_col      <= '0;
            col_out    <= {{(COLS-1){1'b1}}, 1'b0};
            r_scan_end <= 1'b0;
            r_hits     <= 2'd0;
            r_first    <= '0;
        end else begin
            r_scan_end <= w_sample && w_last_col;

            // The scan-end cycle is always a settle phase of column 0, so
            // clearing here never collides with a sample.
            if (r_scan_end) begin
                r_hits  <= 2'd0;
                r_first <= '0;
            end

            if (w_sample) begin
                r_phase <= '0;
                r_col   <= w_last_col ? '0 : r_col + c_COL_W'(1);
                col_out <= {col_out[COLS-2:0], col_out[COLS-1]};
                // Columns are visited in ascending order, so the first
                // column with any hit supplies the reported code.
                if ((r_hits == 2'd0) && (w_col_hits != 2'd0)) begin
                    r_first <= w_col_first;
                end
                r_hits <= (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
            end else begin
                r_phase <= r_phase + c_PH_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce state machine (acts only on scan-end cycles)
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0]   r_cand;

    scan_res_t          w_result;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_cnt_done;
    logic               w_match;

    assign w_result   = classify_hits(r_hits);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_W'(1);
    assign w_cnt_done = (w_cnt_inc >= c_CNT_W'(DEBOUNCE_SCANS));
    assign w_match    = (w_result == RES_SINGLE) && (r_first == r_cand);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            key_code  <= KEY_W'(c_KEY_R0_C0);
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (r_scan_end) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_result == RES_SINGLE) begin
                            r_cand  <= r_first;
                            r_cnt   <= c_CNT_W'(1);
                            r_state <= ST_DEB_PRESS;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (w_match) begin
                            if (w_cnt_done) begin
                                key_code  <= r_cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                r_cnt     <= '0;
                                r_state   <= ST_PRESSED;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        // Any key activity keeps the press alive; no rollover.
                        if (w_result == RES_NONE) begin
                            r_cnt   <= c_CNT_W'(1);
                            r_state <= ST_DEB_RELEASE;
                        end
                    end
                    ST_DEB_RELEASE: begin
                        if (w_result == RES_NONE) begin
                            if (w_cnt_done) begin
                                key_held <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_PRESSED;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner. A keypad model
//                turns a set of pressed keys into row levels from col_out;
//                a scan-level reference model predicts strobes (queued for
//                a monitor), key_held and key_code.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int D = 4;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0;   // bit n set = key with code n pressed
    longint      cyc  = 0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int     code;
        longint t;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int m_held = 0;
    int m_run  = 0;
    int m_key  = 0;
    int m_code = 0;

    keypad_scanner #(
        .COLS           (4),
        .ROWS           (4),
        .DEBOUNCE_SCANS (D),
        .KEY_W          (4)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Passive keypad: a pressed key shorts its row to its column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4 + c]) row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // Monitor: every strobe must match the oldest predicted one.
    always @(negedge clk_in) begin
        if (key_valid) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_code", key_code, e.code);
                check("strobe_cycle", cyc, e.t);
            end
        end
    end

    // One scan's worth of rules applied to the key set that was stable
    // for the whole scan. t0 is the cycle count at the scan's first cycle.
    task automatic model_step(input logic [15:0] ks, input longint t0);
        int n;
        int first;
        n     = $countones(ks);
        first = -1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (first < 0 && ks[r*4 + c]) first = r*4 + c;
        if (m_held == 0) begin
            if (n == 1 && m_run > 0 && first == m_key) begin
                m_run++;
                if (m_run == D) begin
                    m_held = 1;
                    m_code = first;
                    m_run  = 0;
                    q.push_back('{code: first, t: t0 + 13});
                end
            end else if (n == 1 && m_run == 0) begin
                m_key = first;
                m_run = 1;
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_run++;
                if (m_run == D) begin
                    m_held = 0;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // Called on the negedge after a scan's first edge; returns one scan later.
    task automatic run_scan(input logic [15:0] ks);
        longint t0;
        keys = ks;
        t0   = cyc;
        for (int j = 0; j < 12; j++) begin
            check("col_out", col_out, (~(1 << (j / 3))) & 15);
            if (j == 1) begin
                check("key_held", key_held, m_held);
                check("key_code", key_code, m_code);
            end
            @(negedge clk_in);
        end
        model_step(ks, t0);
    endtask

    task automatic run_scans(input logic [15:0] ks, input int n);
        for (int i = 0; i < n; i++) run_scan(ks);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_in);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_key_code", key_code, 0);
        reset  = 1'b0;
        m_held = 0;
        m_run  = 0;
        m_code = 0;
    endtask

    function automatic logic [15:0] k(input int code);
        return 16'(1 << code);
    endfunction

    initial begin
        logic [15:0] ks;
        int          a;
        int          b;
        @(negedge clk_in);
        do_reset();

        // Column rotation with no keys
        run_scans(16'h0, 2);

        // Clean press of key 9 (row 2, col 1) for ~80 cycles, then release
        run_scans(k(9), 7);
        run_scans(16'h0, 5);

        // Bounce: key 3 on for 2 scans, off for 1, five times
        for (int i = 0; i < 5; i++) begin
            run_scans(k(3), 2);
            run_scans(16'h0, 1);
        end

        // Release debounce: short release does not end the press
        run_scans(k(9), 5);
        run_scans(16'h0, 2);
        run_scans(k(9), 3);
        run_scans(16'h0, 5);

        // Multi-key: never accepted; no rollover while pressed
        run_scans(k(5) | k(10), 10);
        run_scans(16'h0, 1);
        run_scans(k(9), 5);
        run_scans(k(9) | k(5), 3);
        run_scans(k(5), 2);
        run_scans(k(9), 2);
        run_scans(16'h0, 5);

        // Reset in DEB_PRESS at cnt = 3, then re-acceptance of key 6
        run_scans(k(6), 3);
        keys = k(6);
        repeat (5) @(negedge clk_in);
        do_reset();
        run_scans(k(6), 6);
        run_scans(16'h0, 5);

        // Randomized segments
        for (int s = 0; s < 24; s++) begin
            a = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: ks = 16'h0;
                1, 2: ks = k(a);
                default: begin
                    b  = (a + 1 + $urandom_range(0, 14)) % 16;
                    ks = k(a) | k(b);
                end
            endcase
            run_scans(ks, $urandom_range(1, 7));
        end

        run_scans(16'h0, 6);
        check("pending_strobes", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_keypad_scanner
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and reports debounced key presses.
- Sits directly downstream of the 50 kHz -> ~1 kHz clock divider; its clk_in is the divider's clk_out.
- Drives the keypad columns active-low, samples the rows, and debounces across whole scans.
- Emits a one-cycle key_valid strobe with the key code to the game/control logic.

Parameters:
- COLS, 4, number of keypad columns driven.
- ROWS, 4, number of keypad rows sampled.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release (range 2..15).
- KEY_W, 4, key code width; equals clog2(ROWS*COLS).

Ports:
- clk_in  input  1  scan clock, ~1 kHz, from the clock divider output
- reset  input  1  synchronous, active-high reset
- row_in  input  ROWS  keypad rows, active-low, external pull-ups, asynchronous to clk_in
- col_out  output  COLS  column drive, active-low one-hot
- key_code  output  KEY_W  last accepted key, code = row*COLS + col
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high while the accepted key is considered down

Behaviour:
- Synchronous design on clk_in only; reset is synchronous, active-high.
- Reset values:
  - col_out = 4'b1110 (column 0 driven).
  - Phase counter and column index = 0.
  - State = IDLE.
  - key_code = 0, key_valid = 0, key_held = 0.
  - Row synchronizer flops = all ones.
- Row synchronizer: row_in passes through two flops before use.
- Column phases:
  - Each column is driven for 3 cycles: phase 0 and 1 settle/sync, phase 2 samples the synchronized rows.
  - After phase 2 the column index advances (wraps COLS-1 -> 0), and col_out rotates to the next column on the same edge.
  - One full scan = 3*COLS = 12 cycles.
- Scan accumulation:
  - Per scan, count pressed keys (a row bit low during a column's phase 2).
  - Record the code of the first pressed key, scanning lowest column first, then lowest row.
- Scan result, evaluated once at scan end (the cycle after column COLS-1 is sampled):
  - NONE: 0 keys.
  - SINGLE(k): exactly 1 key.
  - MULTI: 2 or more keys.
- State machine (transitions only at scan end):
  - IDLE:
    - SINGLE(k) -> cand = k, cnt = 1, go to DEB_PRESS.
    - NONE or MULTI -> stay in IDLE.
  - DEB_PRESS:
    - SINGLE(cand) -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS: key_code <= cand, key_valid = 1 for exactly one cycle, key_held = 1, go to PRESSED.
    - Any other result -> IDLE, cnt = 0; no strobe.
  - PRESSED:
    - NONE -> cnt = 1, go to DEB_RELEASE.
    - SINGLE(cand) -> stay.
    - SINGLE(other) or MULTI -> stay; no rollover, no new strobe.
  - DEB_RELEASE:
    - NONE -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS: key_held = 0, go to IDLE.
    - Any key present -> back to PRESSED, cnt = 0.
- Latency: key_valid rises on the cycle after the scan end of the DEBOUNCE_SCANS-th consecutive matching scan. Worst case from a stable pin press is (DEBOUNCE_SCANS+1)*12 + 2 = 62 cycles.
- key_code holds its value after release until the next accepted press.
- cnt saturates; it never wraps.
- Reset mid-debounce or mid-press: immediate return to the reset values; no strobe is emitted on reset.
- Outputs col_out, key_code, key_valid and key_held are all registered.

Decomposition:
- Shared package keypad_pkg contains:
  - SCAN_PHASES = 3.
  - Scan-result encoding NONE/SINGLE/MULTI.
  - State encoding IDLE/DEB_PRESS/PRESSED/DEB_RELEASE.
  - Key code constants for the game logic.
- One sub-module: row_sync, a parameterized two-flop synchronizer (width ROWS, reset value all ones).

Test Plan:
- Column rotation: release reset, rows all high -> col_out cycles 1110, 1101, 1011, 0111, each held 3 cycles; key_valid stays 0; key_held stays 0.
- Clean press: row 2 low whenever col 1 is driven, held for 80 cycles -> exactly one key_valid pulse with key_code = 9; key_held = 1 within 62 cycles of press onset.
- Bounce rejection: key (0,3) present for 2 scans, absent 1 scan, repeated 5 times -> no key_valid; key_code unchanged.
- Release debounce: after an accepted press of key 9, release for 2 scans then press again -> key_held stays 1 with no second strobe; then release for 5 scans -> key_held = 0.
- Multi-key: keys 5 and 10 pressed together for 10 scans -> no key_valid; from PRESSED(9), adding key 5 -> no strobe and key_code stays 9.
- Reset mid-operation: assert reset during DEB_PRESS at cnt = 3 -> next cycle col_out = 1110, key_valid = 0, key_held = 0; a held key is re-accepted only after 4 full scans.
